// File: rtl/fwrisc_alu_issue_if.sv
// fwrisc_alu_issue_if: issue, ALU and result handshake signals of the execute-stage issuer
interface fwrisc_alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_pc;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        out_wr_en;
  logic        out_br_taken;
  logic        out_illegal;
  modport master (
    input  in_valid, in_instr, in_rs1, in_rs2, in_pc, alu_out, out_ready,
    output in_ready, alu_op_a, alu_op_b, alu_op, out_valid, out_rd, out_result,
           out_wr_en, out_br_taken, out_illegal
  );
  modport slave (
    output in_valid, in_instr, in_rs1, in_rs2, in_pc, alu_out, out_ready,
    input  in_ready, alu_op_a, alu_op_b, alu_op, out_valid, out_rd, out_result,
           out_wr_en, out_br_taken, out_illegal
  );
endinterface

// File: rtl/fwrisc_alu_issue.sv
// fwrisc_alu_issue: RV32I execute-stage issuer driving an external ALU, with an iterative shifter
module fwrisc_alu_issue #(
  parameter int SHIFT_STEP = 1
) (
  input logic clock,
  input logic reset,
  fwrisc_alu_issue_if.master bus
);
  typedef enum logic [1:0] {IDLE, ALU, SHIFT, DONE} state_t;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_EQ = 4'd5, OP_NE = 4'd6, OP_LT = 4'd7, OP_GE = 4'd8;
  localparam logic [3:0] OP_LTU = 4'd9, OP_GEU = 4'd10, OP_OPA = 4'd11, OP_OPB = 4'd12, OP_XOR = 4'd13;
  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011, OPC_BR = 7'b1100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);
  state_t state, state_nxt;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_op;
  logic [31:0] imm_i, imm_u;
  logic [3:0] op_d, op_q;
  logic [31:0] a_d, a_q, b_d, b_q;
  logic ill_d, ill_q, br_d, br_q, slt_d, slt_q, sh_d, sh_q, wr_q, bt_q;
  logic [1:0] kind_d, kind_q;
  logic [4:0] shamt_d, rem_q, step, rem_nxt, rd_q;
  logic [31:0] shreg_q, sra_v, shifted, res_q;
  assign opc = bus.in_instr[6:0];
  assign f3 = bus.in_instr[14:12];
  assign f7 = bus.in_instr[31:25];
  assign is_op = opc == OPC_OP;
  assign imm_i = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_u = {bus.in_instr[31:12], 12'b0};
  // Decode the offered instruction into ALU controls and shifter setup
  always_comb begin
    op_d = OP_OPA;
    a_d = '0;
    b_d = '0;
    ill_d = 1'b0;
    br_d = 1'b0;
    slt_d = 1'b0;
    sh_d = 1'b0;
    kind_d = 2'd0;
    shamt_d = '0;
    case (opc)
      OPC_OP, OPC_IMM: begin
        a_d = bus.in_rs1;
        b_d = is_op ? bus.in_rs2 : imm_i;
        sh_d = f3 == 3'b001 || f3 == 3'b101;
        slt_d = f3 == 3'b010 || f3 == 3'b011;
        kind_d = f3 == 3'b001 ? 2'd0 : f7[5] ? 2'd2 : 2'd1;
        shamt_d = is_op ? bus.in_rs2[4:0] : bus.in_instr[24:20];
        ill_d = is_op ? !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))
              : f3 == 3'b001 ? f7 != 7'h00
              : f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20;
        op_d = f3 == 3'b000 ? (is_op && f7[5] ? OP_SUB : OP_ADD)
             : f3 == 3'b010 ? OP_LT : f3 == 3'b011 ? OP_LTU
             : f3 == 3'b100 ? OP_XOR : f3 == 3'b110 ? OP_OR
             : f3 == 3'b111 ? OP_AND : OP_OPA;
      end
      OPC_BR: begin
        a_d = bus.in_rs1;
        b_d = bus.in_rs2;
        br_d = 1'b1;
        ill_d = f3[2:1] == 2'b01;
        op_d = f3 == 3'b000 ? OP_EQ : f3 == 3'b001 ? OP_NE : f3 == 3'b100 ? OP_LT
             : f3 == 3'b101 ? OP_GE : f3 == 3'b110 ? OP_LTU : f3 == 3'b111 ? OP_GEU : OP_OPA;
      end
      OPC_LUI: begin
        op_d = OP_OPB;
        b_d = imm_u;
      end
      OPC_AUIPC: begin
        op_d = OP_ADD;
        a_d = bus.in_pc;
        b_d = imm_u;
      end
      default: ill_d = 1'b1;
    endcase
    if (ill_d) begin
      op_d = OP_OPA;
      a_d = '0;
      b_d = '0;
      br_d = 1'b0;
      slt_d = 1'b0;
      sh_d = 1'b0;
    end
  end
  assign step = rem_q < STEP ? rem_q : STEP;
  assign rem_nxt = rem_q - step;
  assign sra_v = $signed(shreg_q) >>> step;
  assign shifted = kind_q == 2'd0 ? shreg_q << step : kind_q == 2'd2 ? sra_v : shreg_q >> step;
  // Next state: shifts with a non-zero amount detour through SHIFT before the ALU cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = sh_d && shamt_d != 5'd0 ? SHIFT : ALU;
      ALU: state_nxt = DONE;
      SHIFT: if (rem_nxt == 5'd0) state_nxt = ALU;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // Capture on accept, step the shifter, then register the writeback/branch result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q <= OP_OPA;
      a_q <= '0;
      b_q <= '0;
      ill_q <= 1'b0;
      br_q <= 1'b0;
      slt_q <= 1'b0;
      sh_q <= 1'b0;
      wr_q <= 1'b0;
      bt_q <= 1'b0;
      kind_q <= 2'd0;
      rem_q <= '0;
      rd_q <= '0;
      shreg_q <= '0;
      res_q <= '0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        op_q <= op_d;
        a_q <= a_d;
        b_q <= b_d;
        ill_q <= ill_d;
        br_q <= br_d;
        slt_q <= slt_d;
        sh_q <= sh_d;
        wr_q <= !ill_d && !br_d && bus.in_instr[11:7] != 5'd0;
        kind_q <= kind_d;
        rem_q <= shamt_d;
        rd_q <= bus.in_instr[11:7];
        shreg_q <= bus.in_rs1;
      end
      if (state == SHIFT) begin
        shreg_q <= shifted;
        rem_q <= rem_nxt;
      end
      if (state == ALU) begin
        res_q <= ill_q || br_q ? '0 : sh_q ? shreg_q : slt_q ? {31'b0, bus.alu_out[0]} : bus.alu_out;
        bt_q <= br_q && bus.alu_out[0];
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.alu_op = state == ALU ? op_q : OP_OPA;
  assign bus.alu_op_a = state == ALU ? a_q : '0;
  assign bus.alu_op_b = state == ALU ? b_q : '0;
  assign bus.out_rd = rd_q;
  assign bus.out_result = res_q;
  assign bus.out_wr_en = state == DONE && wr_q;
  assign bus.out_br_taken = state == DONE && bt_q;
  assign bus.out_illegal = state == DONE && ill_q;
endmodule

// File: tb/tb_fwrisc_alu_issue.sv
// tb_fwrisc_alu_issue: scoreboard bench for the issuer with a reference ALU attached
module tb_fwrisc_alu_issue;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  fwrisc_alu_issue_if b1();
  fwrisc_alu_issue_if b4();
  fwrisc_alu_issue #(.SHIFT_STEP(1)) dut1 (.clock(clock), .reset(reset), .bus(b1));
  fwrisc_alu_issue #(.SHIFT_STEP(4)) dut4 (.clock(clock), .reset(reset), .bus(b4));
  logic sel = 1'b0;
  logic iv = 1'b0;
  logic ory = 1'b1;
  logic [31:0] instr = '0, rs1 = '0, rs2 = '0, pc = '0;
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wr;
    logic        br;
    logic        ill;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a & ~b;
      4'd5: return {31'b0, a == b};
      4'd6: return {31'b0, a != b};
      4'd7: return {31'b0, $signed(a) < $signed(b)};
      4'd8: return {31'b0, $signed(a) >= $signed(b)};
      4'd9: return {31'b0, a < b};
      4'd10: return {31'b0, a >= b};
      4'd11: return a;
      4'd12: return b;
      4'd13: return a ^ b;
      default: return '0;
    endcase
  endfunction
  assign b1.alu_out = alu(b1.alu_op, b1.alu_op_a, b1.alu_op_b);
  assign b4.alu_out = alu(b4.alu_op, b4.alu_op_a, b4.alu_op_b);
  assign b1.in_valid = iv && !sel;
  assign b4.in_valid = iv && sel;
  assign b1.in_instr = instr;
  assign b4.in_instr = instr;
  assign b1.in_rs1 = rs1;
  assign b4.in_rs1 = rs1;
  assign b1.in_rs2 = rs2;
  assign b4.in_rs2 = rs2;
  assign b1.in_pc = pc;
  assign b4.in_pc = pc;
  assign b1.out_ready = ory;
  assign b4.out_ready = ory;
  wire o_valid = sel ? b4.out_valid : b1.out_valid;
  wire o_in_ready = sel ? b4.in_ready : b1.in_ready;
  wire [4:0] o_rd = sel ? b4.out_rd : b1.out_rd;
  wire [31:0] o_res = sel ? b4.out_result : b1.out_result;
  wire o_wr = sel ? b4.out_wr_en : b1.out_wr_en;
  wire o_br = sel ? b4.out_br_taken : b1.out_br_taken;
  wire o_ill = sel ? b4.out_illegal : b1.out_illegal;
  wire [3:0] o_op = sel ? b4.alu_op : b1.alu_op;
  wire [31:0] o_a = sel ? b4.alu_op_a : b1.alu_op_a;
  wire [31:0] o_b = sel ? b4.alu_op_b : b1.alu_op_b;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // Architectural RV32I result, independent of the ALU op encoding
  function automatic exp_t ref_model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] r2, input logic [31:0] p);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [31:0] b, sra;
    logic [4:0] sh;
    logic alt, ok, is_r;
    opc = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    e = '0;
    e.rd = i[11:7];
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      is_r = opc == 7'b0110011;
      b = is_r ? r2 : {{20{i[31]}}, i[31:20]};
      sh = is_r ? r2[4:0] : i[24:20];
      alt = f7 == 7'h20;
      ok = f7 == 7'h00 || (alt && (f3 == 3'b101 || (f3 == 3'b000 && is_r)));
      if (!is_r && f3 != 3'b001 && f3 != 3'b101) ok = 1'b1;
      sra = $signed(a) >>> sh;
      case (f3)
        3'b000: e.res = (alt && is_r) ? a - b : a + b;
        3'b001: e.res = a << sh;
        3'b010: e.res = {31'b0, $signed(a) < $signed(b)};
        3'b011: e.res = {31'b0, a < b};
        3'b100: e.res = a ^ b;
        3'b101: e.res = alt ? sra : a >> sh;
        3'b110: e.res = a | b;
        default: e.res = a & b;
      endcase
      e.ill = !ok;
      if (!ok) e.res = '0;
      e.wr = ok && e.rd != 5'd0;
    end else if (opc == 7'b1100011) begin
      case (f3)
        3'b000: e.br = a == r2;
        3'b001: e.br = a != r2;
        3'b100: e.br = $signed(a) < $signed(r2);
        3'b101: e.br = $signed(a) >= $signed(r2);
        3'b110: e.br = a < r2;
        3'b111: e.br = a >= r2;
        default: e.ill = 1'b1;
      endcase
    end else if (opc == 7'b0110111) begin
      e.res = {i[31:12], 12'b0};
      e.wr = e.rd != 5'd0;
    end else if (opc == 7'b0010111) begin
      e.res = p + {i[31:12], 12'b0};
      e.wr = e.rd != 5'd0;
    end else e.ill = 1'b1;
    return e;
  endfunction
  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] btype(input logic [2:0] f3);
    return {7'b0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] utype(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction
  // Issue one instruction, optionally stall the result, then compare against the scoreboard
  task automatic run(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] p,
                     input int hold, input int lat_exp);
    exp_t e;
    int lat;
    @(negedge clock);
    check("idle_in_ready", 32'(o_in_ready), 1);
    instr = i;
    rs1 = r1;
    rs2 = r2;
    pc = p;
    iv = 1'b1;
    ory = hold == 0;
    sb.push_back(ref_model(i, r1, r2, p));
    @(posedge clock);
    #1 iv = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge clock);
      #1 lat++;
    end
    e = sb.pop_front();
    check("out_valid_timeout", 32'(o_valid), 1);
    if (!o_valid) return;
    if (lat_exp != 0) check("latency", lat, lat_exp);
    check("result", o_res, e.res);
    check("rd", 32'(o_rd), 32'(e.rd));
    check("wr_en", 32'(o_wr), 32'(e.wr));
    check("br_taken", 32'(o_br), 32'(e.br));
    check("illegal", 32'(o_ill), 32'(e.ill));
    check("alu_op_idle", 32'(o_op), 11);
    repeat (hold) begin
      @(posedge clock);
      #1;
      check("hold_valid", 32'(o_valid), 1);
      check("hold_result", o_res, e.res);
      check("hold_in_ready", 32'(o_in_ready), 0);
    end
    ory = 1'b1;
    @(posedge clock);
    #1;
    check("release_in_ready", 32'(o_in_ready), 1);
    check("release_valid", 32'(o_valid), 0);
  endtask
  initial begin
    int seen;
    logic [31:0] r1, r2;
    logic [2:0] f3;
    repeat (2) @(negedge clock);
    check("rst_in_ready", 32'(o_in_ready), 1);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_wr_en", 32'(o_wr), 0);
    check("rst_br", 32'(o_br), 0);
    check("rst_illegal", 32'(o_ill), 0);
    check("rst_rd", 32'(o_rd), 0);
    check("rst_result", o_res, 0);
    check("rst_alu_op", 32'(o_op), 11);
    check("rst_op_a", o_a, 0);
    check("rst_op_b", o_b, 0);
    reset = 1'b0;
    run(rtype(7'h00, 3'b000, 5'd3), 32'd5, 32'd7, 32'h0, 0, 2);
    run(rtype(7'h20, 3'b000, 5'd4), 32'd0, 32'd1, 32'h0, 0, 2);
    run(rtype(7'h00, 3'b011, 5'd5), 32'd1, 32'hFFFF_FFFF, 32'h0, 0, 2);
    run(rtype(7'h00, 3'b010, 5'd5), 32'd1, 32'hFFFF_FFFF, 32'h0, 0, 2);
    run(itype({7'h20, 5'd31}, 3'b101, 5'd6), 32'h8000_0000, 32'h0, 32'h0, 0, 33);
    run(btype(3'b111), 32'hFFFF_FFFF, 32'd1, 32'h0, 0, 2);
    run(btype(3'b001), 32'd9, 32'd9, 32'h0, 0, 2);
    run(utype(20'h00001, 5'd7, 7'b0010111), 32'h0, 32'h0, 32'h100, 5, 2);
    run(itype(12'h001, 3'b000, 5'd0), 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 2);
    run(utype(20'hABCDE, 5'd8, 7'b0110111), 32'h0, 32'h0, 32'h0, 0, 2);
    run(itype(12'hFFF, 3'b100, 5'd9), 32'h0F0F_0F0F, 32'h0, 32'h0, 0, 2);
    run(rtype(7'h00, 3'b101, 5'd10), 32'h8000_0000, 32'h0000_0104, 32'h0, 0, 6);
    run(rtype(7'h20, 3'b101, 5'd11), 32'h8000_0001, 32'h0000_0020, 32'h0, 0, 2);
    run(btype(3'b010), 32'd1, 32'd1, 32'h0, 0, 2);
    for (int k = 0; k < 8; k++) begin
      r1 = $urandom;
      r2 = $urandom;
      f3 = 3'($urandom_range(0, 7));
      run(rtype(7'h00, f3, 5'($urandom_range(1, 31))), r1, r2, 32'h0, 0,
          (f3 == 3'b001 || f3 == 3'b101) && r2[4:0] != 5'd0 ? 2 + int'(r2[4:0]) : 2);
    end
    @(negedge clock);
    sel = 1'b1;
    run(itype({7'h20, 5'd31}, 3'b101, 5'd6), 32'h8000_0000, 32'h0, 32'h0, 0, 10);
    run(itype({7'h00, 5'd5}, 3'b001, 5'd12), 32'd3, 32'h0, 32'h0, 0, 4);
    @(negedge clock);
    sel = 1'b0;
    instr = itype({7'h20, 5'd31}, 3'b101, 5'd6);
    rs1 = 32'h8000_0000;
    iv = 1'b1;
    @(posedge clock);
    #1 iv = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_valid", 32'(o_valid), 0);
    check("abort_in_ready", 32'(o_in_ready), 1);
    check("abort_result", o_res, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1 seen |= int'(o_valid);
    end
    check("abort_no_output", seen, 0);
    run(32'h0000_0280, 32'd4, 32'd4, 32'h0, 0, 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
